// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings used by
// every client, the arbiter state type and the default bus widths.
package sdram_pkg;

  localparam int SDRAM_DATA_W = 16;
  localparam int SDRAM_ADDR_W = 12;

  // {cs_n, ras_n, cas_n, we_n} encodings
  localparam logic [3:0] CMD_NOP         = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE   = 4'b0010;
  localparam logic [3:0] CMD_AUTOREFRESH = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE      = 4'b0011;
  localparam logic [3:0] CMD_WRITE       = 4'b0100;
  localparam logic [3:0] CMD_READ        = 4'b0101;
  localparam logic [3:0] CMD_MRS         = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arbState_e;

  // True while some client owns the command bus
  function automatic logic isGrantState(arbState_e s);
    return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational pin mux: routes the owning client's command/bank/address to
// the SDRAM pins and drives the data pad only while a write client asks.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int DATA_W = SDRAM_DATA_W,
  parameter int ADDR_W = SDRAM_ADDR_W
)(
  input  arbState_e         state_i,
  input  logic [3:0]        init_cmd_i,
  input  logic [1:0]        init_ba_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [3:0]        aref_cmd_i,
  input  logic [1:0]        aref_ba_i,
  input  logic [ADDR_W-1:0] aref_addr_i,
  input  logic [3:0]        wr_cmd_i,
  input  logic [1:0]        wr_ba_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [3:0]        rd_cmd_i,
  input  logic [1:0]        rd_ba_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_data_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [3:0]        cmd_o,
  output logic [1:0]        ba_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] dq_out_o,
  output logic              dq_oe_o
);

  // Select the bus of the current owner; idle arbitration shows a NOP
  always_comb begin
    cmd_o    = CMD_NOP;
    ba_o     = 2'b11;
    addr_o   = '1;
    dq_oe_o  = (state_i == ST_WRITE) && wr_data_en_i;
    dq_out_o = '0;
    case (state_i)
      ST_INIT: begin
        cmd_o  = init_cmd_i;
        ba_o   = init_ba_i;
        addr_o = init_addr_i;
      end
      ST_AREF: begin
        cmd_o  = aref_cmd_i;
        ba_o   = aref_ba_i;
        addr_o = aref_addr_i;
      end
      ST_WRITE: begin
        cmd_o  = wr_cmd_i;
        ba_o   = wr_ba_i;
        addr_o = wr_addr_i;
      end
      ST_READ: begin
        cmd_o  = rd_cmd_i;
        ba_o   = rd_ba_i;
        addr_o = rd_addr_i;
      end
      default: begin
        cmd_o  = CMD_NOP;
        ba_o   = 2'b11;
        addr_o = '1;
      end
    endcase
    if (dq_oe_o) begin
      dq_out_o = wr_data_i;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// Command-bus arbiter for the SDRAM controller clients (init, refresh,
// write, read). Priority refresh > write > read, no pre-emption; a sticky
// aref_late flag records a refresh that waited too long for its grant.
// Optional grant watchdog with sticky wdog_err: define SDRAM_ARB_WDOG_EN.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int          DATA_W       = SDRAM_DATA_W,
  parameter int          ADDR_W       = SDRAM_ADDR_W,
`ifdef SDRAM_ARB_WDOG_EN
  parameter logic [15:0] WDOG_MAX     = 16'd4096,
`endif
  parameter logic [9:0]  AREF_LAT_MAX = 10'd64
)(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
`ifdef SDRAM_ARB_WDOG_EN
  output logic              wdog_err,
`endif
  output logic              aref_late
);

  arbState_e   stateQ, stateD;
  logic [9:0]  waitQ, waitD;
  logic        lateQ, lateD;
  logic        grantEnd;
  logic [3:0]  muxCmd;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stateQ <= ST_INIT;
    end else begin
      stateQ <= stateD;
    end
  end

  // The current owner's done pulse; done pulses from other clients are ignored
  always_comb begin
    grantEnd = ((stateQ == ST_AREF)  && aref_end) ||
               ((stateQ == ST_WRITE) && wr_end)   ||
               ((stateQ == ST_READ)  && rd_end);
  end

`ifdef SDRAM_ARB_WDOG_EN
  logic [15:0] wdogQ, wdogD;
  logic        wdogErrQ;
  logic        wdogExpire;

  // A grant that has lasted WDOG_MAX cycles without its done pulse is revoked
  always_comb begin
    wdogD      = isGrantState(stateQ) ? (wdogQ + 16'd1) : 16'd0;
    wdogExpire = isGrantState(stateQ) && !grantEnd && (wdogQ >= (WDOG_MAX - 16'd1));
  end

  // Grant timer and sticky watchdog error
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wdogQ    <= 16'd0;
      wdogErrQ <= 1'b0;
    end else begin
      wdogQ    <= wdogD;
      wdogErrQ <= wdogErrQ | wdogExpire;
    end
  end

  assign wdog_err = wdogErrQ;
`endif

  // Next state: strict priority from ARBIT, grants held until their done pulse
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_INIT: begin
        if (init_end) stateD = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req)    stateD = ST_AREF;
        else if (wr_req) stateD = ST_WRITE;
        else if (rd_req) stateD = ST_READ;
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        if (grantEnd) stateD = ST_ARBIT;
      end
      default: stateD = ST_INIT;
    endcase
`ifdef SDRAM_ARB_WDOG_EN
    if (wdogExpire) stateD = ST_ARBIT;
`endif
  end

  // Grants drop in the done cycle so a client cannot relaunch a command
  always_comb begin
    aref_en = (stateQ == ST_AREF)  && !aref_end;
    wr_en   = (stateQ == ST_WRITE) && !wr_end;
    rd_en   = (stateQ == ST_READ)  && !rd_end;
  end

  // Refresh wait counter saturates; lateness latches once the limit is reached
  always_comb begin
    waitD = 10'd0;
    if (aref_req && (stateQ != ST_AREF)) begin
      waitD = (waitQ == 10'h3FF) ? waitQ : (waitQ + 10'd1);
    end
    lateD = lateQ | (waitD >= AREF_LAT_MAX);
  end

  // Wait counter and sticky late flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      waitQ <= 10'd0;
      lateQ <= 1'b0;
    end else begin
      waitQ <= waitD;
      lateQ <= lateD;
    end
  end

  assign aref_late = lateQ;
  assign sdram_cke = ~sys_rst;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = muxCmd;

  sdram_cmd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uCmdMux (
    .state_i      (stateQ),
    .init_cmd_i   (init_cmd),
    .init_ba_i    (init_ba),
    .init_addr_i  (init_addr),
    .aref_cmd_i   (aref_cmd),
    .aref_ba_i    (aref_ba),
    .aref_addr_i  (aref_addr),
    .wr_cmd_i     (wr_cmd),
    .wr_ba_i      (wr_ba),
    .wr_addr_i    (wr_addr),
    .rd_cmd_i     (rd_cmd),
    .rd_ba_i      (rd_ba),
    .rd_addr_i    (rd_addr),
    .wr_data_en_i (wr_data_en),
    .wr_data_i    (wr_data),
    .cmd_o        (muxCmd),
    .ba_o         (sdram_ba),
    .addr_o       (sdram_addr),
    .dq_out_o     (sdram_dq_out),
    .dq_oe_o      (sdram_dq_oe)
  );

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: emulated clients issue randomized and directed
// requests, a reference model of bus ownership predicts every cycle's pins
// and grants into a queue, and a monitor compares them on the falling edge.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int DW     = 16;
  localparam int AW     = 12;
  localparam int LATMAX = 64;
`ifdef SDRAM_ARB_WDOG_EN
  localparam int WDOGMAX = 16;
`endif

  // Bench owner codes
  localparam int O_INIT = 0;
  localparam int O_IDLE = 1;
  localparam int O_AREF = 2;
  localparam int O_WR   = 3;
  localparam int O_RD   = 4;

  logic          sys_clk, sys_rst, init_end;
  logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]    init_ba, aref_ba, wr_ba, rd_ba;
  logic [AW-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic          aref_req, aref_end, aref_en;
  logic          wr_req, wr_end, wr_en, wr_data_en;
  logic [DW-1:0] wr_data;
  logic          rd_req, rd_end, rd_en;
  logic          sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]    sdram_ba;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_dq_out;
  logic          sdram_dq_oe, aref_late;
`ifdef SDRAM_ARB_WDOG_EN
  logic          wdog_err;
`endif

  typedef struct {
    int            cycle;
    bit            rstCycle;
    logic          cke, arefEn, wrEn, rdEn, oe, late, wdogErr;
    logic [3:0]    cmd;
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    logic [DW-1:0] dq;
  } expect_t;

  expect_t expQ[$];
  expect_t monE;

  int checks = 0;
  int fails  = 0;
  int cycleNo = 0;

  // Reference model state
  int owner = O_INIT;
  int mWait = 0;
  bit mLate = 0;
  bit mErr  = 0;
  int age   = 0;

  // Client emulation knobs and state (index 0 refresh, 1 write, 2 read)
  bit rstKnob = 1, initEndKnob = 0;
  bit randomReq = 0, randomBus = 0, strayEnd = 0;
  bit reqOn[3];
  int lenC[3];

  sdram_arbit #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
`ifdef SDRAM_ARB_WDOG_EN
    .WDOG_MAX     (16'(WDOGMAX)),
`endif
    .AREF_LAT_MAX (10'(LATMAX))
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .init_end     (init_end),
    .init_cmd     (init_cmd),
    .init_ba      (init_ba),
    .init_addr    (init_addr),
    .aref_req     (aref_req),
    .aref_end     (aref_end),
    .aref_cmd     (aref_cmd),
    .aref_ba      (aref_ba),
    .aref_addr    (aref_addr),
    .aref_en      (aref_en),
    .wr_req       (wr_req),
    .wr_end       (wr_end),
    .wr_cmd       (wr_cmd),
    .wr_ba        (wr_ba),
    .wr_addr      (wr_addr),
    .wr_data_en   (wr_data_en),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .rd_req       (rd_req),
    .rd_end       (rd_end),
    .rd_cmd       (rd_cmd),
    .rd_ba        (rd_ba),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .sdram_cke    (sdram_cke),
    .sdram_cs_n   (sdram_cs_n),
    .sdram_ras_n  (sdram_ras_n),
    .sdram_cas_n  (sdram_cas_n),
    .sdram_we_n   (sdram_we_n),
    .sdram_ba     (sdram_ba),
    .sdram_addr   (sdram_addr),
    .sdram_dq_out (sdram_dq_out),
    .sdram_dq_oe  (sdram_dq_oe),
`ifdef SDRAM_ARB_WDOG_EN
    .wdog_err     (wdog_err),
`endif
    .aref_late    (aref_late)
  );

  // Clock starts high so the first falling edge precedes the first rising edge
  initial sys_clk = 1'b1;
  always #5 sys_clk = ~sys_clk;

  task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare one cycle's outputs against the model's prediction
  task automatic checkOutput(input expect_t e);
    cmpVal("cke", 32'(sdram_cke), 32'(e.cke), e.cycle);
    if (!e.rstCycle) begin
      cmpVal("aref_en", 32'(aref_en), 32'(e.arefEn), e.cycle);
      cmpVal("wr_en", 32'(wr_en), 32'(e.wrEn), e.cycle);
      cmpVal("rd_en", 32'(rd_en), 32'(e.rdEn), e.cycle);
      cmpVal("cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(e.cmd), e.cycle);
      cmpVal("ba", 32'(sdram_ba), 32'(e.ba), e.cycle);
      cmpVal("addr", 32'(sdram_addr), 32'(e.addr), e.cycle);
      cmpVal("dq_oe", 32'(sdram_dq_oe), 32'(e.oe), e.cycle);
      cmpVal("dq_out", 32'(sdram_dq_out), 32'(e.dq), e.cycle);
      cmpVal("aref_late", 32'(aref_late), 32'(e.late), e.cycle);
`ifdef SDRAM_ARB_WDOG_EN
      cmpVal("wdog_err", 32'(wdog_err), 32'(e.wdogErr), e.cycle);
`endif
    end
  endtask

  // Monitor: one prediction per cycle, checked mid-cycle
  always @(negedge sys_clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput(monE);
    end
  end

  // Advance the ownership model across one rising edge using the held inputs
  task automatic updateModel();
    int nxt;
    bit ownerDone;
    if (sys_rst) begin
      owner = O_INIT;
      mWait = 0;
      mLate = 0;
      mErr  = 0;
      age   = 0;
      return;
    end
    if (aref_req && owner != O_AREF) mWait = (mWait < 1023) ? mWait + 1 : 1023;
    else mWait = 0;
    if (mWait >= LATMAX) mLate = 1;
    ownerDone = (owner == O_AREF && aref_end) || (owner == O_WR && wr_end) ||
                (owner == O_RD && rd_end);
    nxt = owner;
    if (owner == O_INIT) begin
      if (init_end) nxt = O_IDLE;
    end else if (owner == O_IDLE) begin
      if (aref_req)    nxt = O_AREF;
      else if (wr_req) nxt = O_WR;
      else if (rd_req) nxt = O_RD;
    end else if (ownerDone) begin
      nxt = O_IDLE;
    end
`ifdef SDRAM_ARB_WDOG_EN
    if (owner >= O_AREF && !ownerDone && age == WDOGMAX - 1) begin
      nxt  = O_IDLE;
      mErr = 1;
    end
`endif
    age   = (nxt == owner && owner >= O_AREF) ? age + 1 : 0;
    owner = nxt;
  endtask

  // Drive all inputs for the coming cycle from the client emulators
  task automatic applyStimulus();
    bit reqV[3];
    bit endV[3];
    sys_rst  = rstKnob;
    init_end = initEndKnob;
    for (int c = 0; c < 3; c++) begin
      bit granted;
      granted = (owner == c + 2);
      if (sys_rst) reqOn[c] = 0;
      if (granted) reqOn[c] = 0;
      else if (randomReq && !sys_rst && !reqOn[c] && $urandom_range(0, 7) == 0) begin
        reqOn[c] = 1;
        lenC[c]  = $urandom_range(1, 20);
      end
      reqV[c] = reqOn[c] && !granted;
      endV[c] = granted && (age == lenC[c] - 1);
      if (!granted && strayEnd && $urandom_range(0, 5) == 0) endV[c] = 1;
    end
    aref_req = reqV[0]; aref_end = endV[0];
    wr_req   = reqV[1]; wr_end   = endV[1];
    rd_req   = reqV[2]; rd_end   = endV[2];
    if (randomBus) begin
      init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = AW'($urandom);
      aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = AW'($urandom);
      wr_cmd   = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = AW'($urandom);
      rd_cmd   = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = AW'($urandom);
      wr_data  = DW'($urandom); wr_data_en = 1'($urandom);
    end else begin
      init_cmd = CMD_MRS;       init_ba = 2'b01; init_addr = 12'h123;
      aref_cmd = CMD_PRECHARGE; aref_ba = 2'b10; aref_addr = 12'h400;
      wr_cmd   = CMD_WRITE;     wr_ba   = 2'b00; wr_addr   = 12'h0A5;
      rd_cmd   = CMD_READ;      rd_ba   = 2'b11; rd_addr   = 12'h0F0;
      wr_data  = 16'hA5A5;      wr_data_en = 1'b1;
    end
  endtask

  // Predict this cycle's outputs from bus ownership and the driven inputs
  task automatic pushExpect();
    expect_t e;
    e.cycle    = cycleNo;
    e.rstCycle = sys_rst;
    e.cke      = !sys_rst;
    e.arefEn   = (owner == O_AREF) && !aref_end;
    e.wrEn     = (owner == O_WR) && !wr_end;
    e.rdEn     = (owner == O_RD) && !rd_end;
    case (owner)
      O_INIT:  begin e.cmd = init_cmd; e.ba = init_ba; e.addr = init_addr; end
      O_AREF:  begin e.cmd = aref_cmd; e.ba = aref_ba; e.addr = aref_addr; end
      O_WR:    begin e.cmd = wr_cmd;   e.ba = wr_ba;   e.addr = wr_addr;   end
      O_RD:    begin e.cmd = rd_cmd;   e.ba = rd_ba;   e.addr = rd_addr;   end
      default: begin e.cmd = 4'b0111;  e.ba = 2'b11;   e.addr = {AW{1'b1}}; end
    endcase
    e.oe      = (owner == O_WR) && wr_data_en;
    e.dq      = e.oe ? wr_data : '0;
    e.late    = mLate;
    e.wdogErr = mErr;
    expQ.push_back(e);
  endtask

  task automatic cycleStep();
    @(posedge sys_clk);
    updateModel();
    cycleNo++;
    #1;
    applyStimulus();
    pushExpect();
  endtask

  task automatic startReq(input int c, input int len);
    reqOn[c] = 1;
    lenC[c]  = len;
  endtask

  task automatic waitOwner(input int target, input int budget);
    int n;
    n = 0;
    while (owner != target && n < budget) begin
      cycleStep();
      n++;
    end
    checks++;
    if (owner != target) begin
      fails++;
      $display("[TB] FAIL waitOwner: owner %0d after %0d cycles, wanted %0d", owner, n, target);
    end
  endtask

  task automatic waitQuiet(input int budget);
    int n;
    n = 0;
    while ((owner != O_IDLE || reqOn[0] || reqOn[1] || reqOn[2]) && n < budget) begin
      cycleStep();
      n++;
    end
    checks++;
    if (owner != O_IDLE) begin
      fails++;
      $display("[TB] FAIL waitQuiet: owner %0d after %0d cycles", owner, n);
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      reqOn[c] = 0;
      lenC[c]  = 1;
    end
    applyStimulus();
    pushExpect();

    // Reset, then a long initialisation before init_end
    repeat (3) cycleStep();
    rstKnob = 0;
    repeat (20) cycleStep();
    initEndKnob = 1;
    repeat (3) cycleStep();

    // Simultaneous refresh and write requests: refresh first, write after
    startReq(0, 4);
    startReq(1, 6);
    waitOwner(O_AREF, 10);
    waitOwner(O_WR, 20);
    waitOwner(O_IDLE, 20);

    // Read grant, data pad must stay off
    startReq(2, 5);
    waitOwner(O_RD, 10);
    waitOwner(O_IDLE, 20);

    // Done pulses from idle clients during a write are ignored
    strayEnd = 1;
    startReq(1, 8);
    waitOwner(O_WR, 10);
    waitOwner(O_IDLE, 20);
    strayEnd = 0;

    // Refresh starved behind a long write sets aref_late
    startReq(1, 100);
    waitOwner(O_WR, 10);
    startReq(0, 3);
    waitOwner(O_AREF, 200);
    waitOwner(O_IDLE, 20);
    repeat (3) cycleStep();

    // Random traffic with random buses and stray done pulses
    randomReq = 1;
    randomBus = 1;
    strayEnd  = 1;
    repeat (2000) cycleStep();

    // Reset in the middle of a write grant, then re-initialise
    randomReq = 0;
    waitQuiet(400);
    startReq(1, 30);
    waitOwner(O_WR, 10);
    repeat (5) cycleStep();
    rstKnob = 1;
    repeat (2) cycleStep();
    rstKnob     = 0;
    initEndKnob = 0;
    repeat (5) cycleStep();
    initEndKnob = 1;
    randomReq   = 1;
    repeat (1500) cycleStep();

`ifdef SDRAM_ARB_WDOG_EN
    // Read that never finishes is revoked by the watchdog
    randomReq = 0;
    strayEnd  = 0;
    waitQuiet(400);
    startReq(2, 0);
    waitOwner(O_RD, 10);
    waitOwner(O_IDLE, WDOGMAX + 5);
    repeat (3) cycleStep();
`endif

    repeat (2) @(negedge sys_clk);
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d predictions left unchecked", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Command-bus arbiter and responder for the SDRAM controller's clients: init, auto-refresh, write and read.
- Accepts the refresh engine's aref_req, grants it with aref_en, and closes the grant on aref_end.
- Muxes the granted client's command, bank and address onto the SDRAM pins.
- Priority: refresh > write > read.

Parameters:
- DATA_W, 16, SDRAM data width.
- ADDR_W, 12, SDRAM address width.
- AREF_LAT_MAX, 10'd64, maximum cycles aref_req may wait for a grant before aref_late is set.
- WDOG_MAX, 16'd4096, maximum grant length in cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- init_end  in  1  initialisation complete (level)
- init_cmd/init_ba/init_addr  in  4/2/ADDR_W  init client bus
- aref_req  in  1  refresh request (level, held until the client starts)
- aref_end  in  1  refresh done, 1-cycle pulse
- aref_cmd/aref_ba/aref_addr  in  4/2/ADDR_W  refresh client bus
- aref_en  out  1  refresh grant
- wr_req, wr_end  in  1  write request (level) / done pulse
- wr_cmd/wr_ba/wr_addr  in  4/2/ADDR_W  write client bus
- wr_data_en  in  1  write client drives data
- wr_data  in  DATA_W  write data
- wr_en  out  1  write grant
- rd_req, rd_end  in  1  read request / done pulse
- rd_cmd/rd_ba/rd_addr  in  4/2/ADDR_W  read client bus
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins; {cs,ras,cas,we} = selected cmd
- sdram_ba  out  2  bank address pins
- sdram_addr  out  ADDR_W  address pins
- sdram_dq_out  out  DATA_W  data to the pad
- sdram_dq_oe  out  1  data-pad output enable
- aref_late  out  1  sticky flag: refresh grant was late

Behaviour:
- One clock (sys_clk). Reset is synchronous, active-high (sys_rst).
- FSM states: INIT, ARBIT, AREF, WRITE, READ.
- Reset → INIT, aref_late=0, wait counter=0.
- INIT: pins carry the init bus; moves to ARBIT on the first cycle init_end=1.
- ARBIT:
  - If aref_req → AREF.
  - Else if wr_req → WRITE.
  - Else if rd_req → READ.
  - Else stay.
  - Decision takes effect the next cycle; simultaneous requests resolve strictly by that priority.
- AREF/WRITE/READ: return to ARBIT the cycle after the matching *_end=1. Other requests are ignored until then; no pre-emption.
- Grants are combinational:
  - aref_en = (state==AREF) & ~aref_end; wr_en and rd_en likewise.
  - The grant drops in the same cycle as *_end so the client cannot re-launch.
- Pin mux is combinational from state; it adds no latency.
  - INIT → init bus; AREF → aref bus; WRITE → wr bus; READ → rd bus.
  - ARBIT → NOP 4'b0111, ba=2'b11, addr all-ones.
- sdram_cke=1 at all times except during reset (0).
- sdram_dq_oe = (state==WRITE) & wr_data_en.
- sdram_dq_out = wr_data when sdram_dq_oe=1, else 0.
- Latency counter:
  - Counts while aref_req=1 and state≠AREF; clears when state==AREF or aref_req=0.
  - Saturates at all-ones.
  - When it reaches AREF_LAT_MAX, aref_late←1 and stays set until reset.
- Reset mid-grant: immediate return to INIT, grants drop, pins go to the init bus. Clients must be reset together with the arbiter.
- *_end for a non-granted client is ignored.
- Command encodings: NOP 4'b0111, PRECHARGE 4'b0010, AUTOREFRESH 4'b0001, ACTIVE 4'b0011, WRITE 4'b0100, READ 4'b0101, MRS 4'b0000.

Optional Feature:
- Macro: SDRAM_ARB_WDOG_EN.
- Enabled:
  - A 16-bit grant timer runs in AREF, WRITE and READ.
  - If it reaches WDOG_MAX without *_end, the FSM forces ARBIT and the grant drops.
  - Extra output port wdog_err (1 bit, sticky until reset) sets to 1.
- Disabled: no timer and no wdog_err port; a grant lasts until *_end.

Decomposition:
- Package sdram_pkg holds:
  - the command encodings;
  - the arbiter state enum;
  - DATA_W/ADDR_W defaults.
- The refresh engine and the other clients share these encodings.
- One sub-module, sdram_cmd_mux: purely combinational pin mux and dq drive, selected by state.

Test Plan:
- Reset release, init_end=0 for 20 cycles, then 1 → pins follow init bus throughout; state ARBIT the cycle after init_end; sdram_cke=1 after reset.
- aref_req and wr_req both rise in ARBIT → aref_en=1 next cycle.
  - aref_cmd=4'b0010 appears on the pins that same cycle.
  - After the aref_end pulse, aref_en=0 in that cycle; wr_en=1 two cycles later.
- Write grant with wr_data_en=1, wr_data=16'hA5A5 → sdram_dq_oe=1, dq_out=16'hA5A5. In READ or ARBIT, dq_oe=0.
- aref_req rises while a 100-cycle write is granted, AREF_LAT_MAX=64 → aref_late=1 at wait count 64; stays 1 after the refresh completes.
- rd_end pulse while in WRITE → ignored; state stays WRITE; rd_en remains 0.
- With SDRAM_ARB_WDOG_EN, WDOG_MAX=16, read grant with no rd_end → ARBIT after 16 cycles; wdog_err=1; rd_en=0.
